udma_uart_core: RTL and testbench

Single-clock UART peripheral for the uDMA subsystem. It holds the UART configuration and status registers behind the uDMA config bus. It also drives the RX/TX uDMA channel configuration. Bytes are pulled from the uDMA TX data port and serialized onto `uart_tx_o`; characters are deserialized from `uart_rx_i` and pushed to the uDMA RX data port, with character and error events for the event unit.

---
 rtl/udma_uart_core.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_udma_uart_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_uart_core.sv
`timescale 1ns/1ps
// Purpose: uDMA UART peripheral: config/status registers, channel config, TX serializer, RX deserializer.
// Latency: register writes visible next cycle; TX line falls the cycle after data accept; RX valid <=3 cycles after stop sample.
// Backpressure: TX pulls bytes by req/gnt then valid/ready; RX holds data_rx_valid_o until data_rx_ready_i, overruns are dropped.
// Ports: cfg_* = register bus and uDMA channel config/status; data_tx_* / data_rx_* = uDMA data ports;
//        uart_rx_i / uart_tx_o = serial line (idle high); rx_char_event_o / err_event_o = event unit pulses.
module udma_uart_core #(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4:0]                cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic                      cfg_ready_o,
  output logic [31:0]               cfg_data_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_tx_size_o,
  output logic [1:0]                cfg_tx_datasize_o,
  output logic                      cfg_tx_continuous_o,
  output logic                      cfg_tx_en_o,
  output logic                      cfg_tx_clr_o,
  input  logic                      cfg_tx_en_i,
  input  logic                      cfg_tx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,
  output logic                      data_tx_req_o,
  input  logic                      data_tx_gnt_i,
  output logic [1:0]                data_tx_datasize_o,
  input  logic [31:0]               data_tx_i,
  input  logic                      data_tx_valid_i,
  output logic                      data_tx_ready_o,
  output logic [31:0]               data_rx_o,
  output logic [1:0]                data_rx_datasize_o,
  output logic                      data_rx_valid_o,
  input  logic                      data_rx_ready_i,
  input  logic                      uart_rx_i,
  output logic                      uart_tx_o,
  output logic                      rx_char_event_o,
  output logic                      err_event_o
);

  localparam logic [4:0] ADDR_RX_SADDR = 5'h00, ADDR_RX_SIZE = 5'h01, ADDR_RX_CFG = 5'h02;
  localparam logic [4:0] ADDR_TX_SADDR = 5'h04, ADDR_TX_SIZE = 5'h05, ADDR_TX_CFG = 5'h06;
  localparam logic [4:0] ADDR_STATUS = 5'h08, ADDR_SETUP = 5'h09, ADDR_ERROR = 5'h0A, ADDR_IRQ_EN = 5'h0B;

  typedef enum logic [2:0] {TX_IDLE, TX_REQ, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  logic        parity_en_q, stop_two_q, tx_ena_q, rx_ena_q;
  logic [1:0]  char_len_q;
  logic [15:0] clkdiv_q;
  logic [1:0]  err_q;
  logic [1:0]  irq_en_q;

  logic cfg_wr, cfg_rd;
  assign cfg_wr = cfg_valid_i & ~cfg_rwn_i;
  assign cfg_rd = cfg_valid_i &  cfg_rwn_i;

  assign cfg_ready_o        = 1'b1;
  assign cfg_rx_datasize_o  = 2'b00;
  assign cfg_tx_datasize_o  = 2'b00;
  assign data_tx_datasize_o = 2'b00;
  assign data_rx_datasize_o = 2'b00;

  logic unused_ok;
  assign unused_ok = ^data_tx_i[31:8];

  // Index of the last data bit (char length 5..8 -> 4..7) and mask of valid data bits.
  logic [2:0] last_bit;
  logic [7:0] len_mask;
  assign last_bit = {1'b0, char_len_q} + 3'd4;
  always_comb begin
    len_mask = 8'hFF;
    case (char_len_q)
      2'b00:   len_mask = 8'h1F;
      2'b01:   len_mask = 8'h3F;
      2'b10:   len_mask = 8'h7F;
      default: len_mask = 8'hFF;
    endcase
  end

  // ---------------- configuration registers ----------------
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      cfg_rx_startaddr_o <= '0; cfg_rx_size_o <= '0; cfg_rx_continuous_o <= 1'b0;
      cfg_tx_startaddr_o <= '0; cfg_tx_size_o <= '0; cfg_tx_continuous_o <= 1'b0;
      cfg_rx_en_o <= 1'b0; cfg_rx_clr_o <= 1'b0; cfg_tx_en_o <= 1'b0; cfg_tx_clr_o <= 1'b0;
      parity_en_q <= 1'b0; char_len_q <= 2'b00; stop_two_q <= 1'b0;
      tx_ena_q <= 1'b0; rx_ena_q <= 1'b0; clkdiv_q <= '0; irq_en_q <= 2'b00;
    end else begin
      cfg_rx_en_o <= 1'b0; cfg_rx_clr_o <= 1'b0; cfg_tx_en_o <= 1'b0; cfg_tx_clr_o <= 1'b0;
      if (cfg_wr) begin
        case (cfg_addr_i)
          ADDR_RX_SADDR: cfg_rx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          ADDR_RX_SIZE:  cfg_rx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
          ADDR_RX_CFG: begin
            cfg_rx_continuous_o <= cfg_data_i[0];
            cfg_rx_en_o         <= cfg_data_i[4];
            cfg_rx_clr_o        <= cfg_data_i[5];
          end
          ADDR_TX_SADDR: cfg_tx_startaddr_o <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          ADDR_TX_SIZE:  cfg_tx_size_o      <= cfg_data_i[TRANS_SIZE-1:0];
          ADDR_TX_CFG: begin
            cfg_tx_continuous_o <= cfg_data_i[0];
            cfg_tx_en_o         <= cfg_data_i[4];
            cfg_tx_clr_o        <= cfg_data_i[5];
          end
          ADDR_SETUP: begin
            parity_en_q <= cfg_data_i[0];
            char_len_q  <= cfg_data_i[2:1];
            stop_two_q  <= cfg_data_i[3];
            tx_ena_q    <= cfg_data_i[8];
            rx_ena_q    <= cfg_data_i[9];
            clkdiv_q    <= cfg_data_i[31:16];
          end
          ADDR_IRQ_EN: irq_en_q <= cfg_data_i[1:0];
          default: ;
        endcase
      end
    end
  end

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;
  logic tx_busy, rx_busy;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign rx_busy = (rx_state_q != RX_IDLE);

  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      ADDR_RX_SADDR: cfg_data_o = 32'(cfg_rx_curr_addr_i);
      ADDR_RX_SIZE:  cfg_data_o = 32'(cfg_rx_bytes_left_i);
      ADDR_RX_CFG:   cfg_data_o = {26'b0, cfg_rx_pending_i, cfg_rx_en_i, 3'b0, cfg_rx_continuous_o};
      ADDR_TX_SADDR: cfg_data_o = 32'(cfg_tx_curr_addr_i);
      ADDR_TX_SIZE:  cfg_data_o = 32'(cfg_tx_bytes_left_i);
      ADDR_TX_CFG:   cfg_data_o = {26'b0, cfg_tx_pending_i, cfg_tx_en_i, 3'b0, cfg_tx_continuous_o};
      ADDR_STATUS:   cfg_data_o = {30'b0, rx_busy, tx_busy};
      ADDR_SETUP:    cfg_data_o = {clkdiv_q, 6'b0, rx_ena_q, tx_ena_q, 4'b0, stop_two_q, char_len_q, parity_en_q};
      ADDR_ERROR:    cfg_data_o = {30'b0, err_q};
      ADDR_IRQ_EN:   cfg_data_o = {30'b0, irq_en_q};
      default:       cfg_data_o = '0;
    endcase
  end

  // ---------------- TX ----------------
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_idx_q;
  logic [7:0]  tx_shreg_q;
  logic        tx_par_q, tx_stop_q, tx_tick;
  assign tx_tick = (tx_cnt_q == clkdiv_q);

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) tx_state_q <= TX_IDLE;
    else       tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d      = tx_state_q;
    data_tx_req_o   = 1'b0;
    data_tx_ready_o = 1'b0;
    uart_tx_o       = 1'b1;
    case (tx_state_q)
      TX_IDLE: if (tx_ena_q) tx_state_d = TX_REQ;
      TX_REQ: begin
        data_tx_req_o = 1'b1;
        if (data_tx_gnt_i) tx_state_d = TX_WAIT;
      end
      TX_WAIT: begin
        data_tx_ready_o = 1'b1;
        if (data_tx_valid_i) tx_state_d = TX_START;
      end
      TX_START: begin
        uart_tx_o = 1'b0;
        if (tx_tick) tx_state_d = TX_DATA;
      end
      TX_DATA: begin
        uart_tx_o = tx_shreg_q[0];
        if (tx_tick && (tx_bit_idx_q == last_bit)) tx_state_d = parity_en_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        uart_tx_o = tx_par_q;
        if (tx_tick) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_tick && (tx_stop_q || !stop_two_q)) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      tx_cnt_q <= '0; tx_bit_idx_q <= '0; tx_shreg_q <= '0; tx_par_q <= 1'b0; tx_stop_q <= 1'b0;
    end else begin
      // Bit-period counter runs only while the line is being driven by the frame.
      if (tx_state_q inside {TX_START, TX_DATA, TX_PARITY, TX_STOP})
        tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 16'd1;
      else
        tx_cnt_q <= '0;
      case (tx_state_q)
        TX_WAIT: if (data_tx_valid_i) begin
          tx_shreg_q   <= data_tx_i[7:0];
          tx_par_q     <= ^(data_tx_i[7:0] & len_mask);
          tx_bit_idx_q <= '0;
          tx_stop_q    <= 1'b0;
        end
        TX_DATA: if (tx_tick) begin
          tx_shreg_q   <= {1'b0, tx_shreg_q[7:1]};
          tx_bit_idx_q <= tx_bit_idx_q + 3'd1;
        end
        TX_STOP: if (tx_tick) tx_stop_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q, rx_line;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_idx_q;
  logic [7:0]  rx_data_q;
  logic        rx_par_q, rx_tick, char_done, par_err, ovf_set, par_set;
  assign rx_line = rx_sync_q[1];
  // Start bit is checked at half a period so later samples land at bit centres.
  assign rx_tick = (rx_state_q == RX_START) ? (rx_cnt_q == {1'b0, clkdiv_q[15:1]}) : (rx_cnt_q == clkdiv_q);

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    char_done  = 1'b0;
    case (rx_state_q)
      RX_IDLE:   if (rx_ena_q && rx_prev_q && !rx_line) rx_state_d = RX_START;
      RX_START:  if (rx_tick) rx_state_d = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_tick && (rx_bit_idx_q == last_bit)) rx_state_d = parity_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_state_d = RX_STOP;
      RX_STOP: if (rx_tick) begin
        rx_state_d = RX_IDLE;
        char_done  = 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      rx_sync_q <= 2'b11; rx_prev_q <= 1'b1; rx_cnt_q <= '0;
      rx_bit_idx_q <= '0; rx_data_q <= '0; rx_par_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rx_i};
      rx_prev_q <= rx_line;
      if (rx_state_q != RX_IDLE)
        rx_cnt_q <= rx_tick ? '0 : rx_cnt_q + 16'd1;
      else
        rx_cnt_q <= '0;
      case (rx_state_q)
        RX_START: if (rx_tick && !rx_line) begin
          rx_data_q <= '0; rx_bit_idx_q <= '0; rx_par_q <= 1'b0;
        end
        RX_DATA: if (rx_tick) begin
          rx_data_q[rx_bit_idx_q] <= rx_line;
          rx_bit_idx_q            <= rx_bit_idx_q + 3'd1;
        end
        RX_PARITY: if (rx_tick) rx_par_q <= rx_line;
        default: ;
      endcase
    end
  end

  // Unused high data bits are zero, so the XOR covers only the configured length.
  assign par_err = parity_en_q & (rx_par_q != ^rx_data_q);
  assign ovf_set = char_done & data_rx_valid_o;
  assign par_set = char_done & par_err;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      data_rx_o <= '0; data_rx_valid_o <= 1'b0; rx_char_event_o <= 1'b0;
      err_event_o <= 1'b0; err_q <= 2'b00;
    end else begin
      if (data_rx_valid_o && data_rx_ready_i) data_rx_valid_o <= 1'b0;
      if (char_done && !data_rx_valid_o) begin
        data_rx_o       <= {24'b0, rx_data_q};
        data_rx_valid_o <= 1'b1;
      end
      rx_char_event_o <= char_done & ~data_rx_valid_o & irq_en_q[0];
      err_event_o     <= (ovf_set | par_set) & irq_en_q[1];
      // Read-to-clear; a new error in the same cycle survives the clear.
      err_q[0] <= ovf_set | (err_q[0] & ~(cfg_rd && cfg_addr_i == ADDR_ERROR));
      err_q[1] <= par_set | (err_q[1] & ~(cfg_rd && cfg_addr_i == ADDR_ERROR));
    end
  end

endmodule

// File: tb/tb_udma_uart_core.sv
`timescale 1ns/1ps
module tb_udma_uart_core;
  localparam int AW = 19;
  localparam int TS = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cfg_data_i, cfg_data_o;
  logic [4:0]    cfg_addr;
  logic          cfg_valid, cfg_rwn, cfg_ready;
  logic [AW-1:0] rx_saddr, tx_saddr, rx_curr, tx_curr;
  logic [TS-1:0] rx_size, tx_size, rx_left, tx_left;
  logic [1:0]    rx_dsz, tx_dsz, dtx_dsz, drx_dsz;
  logic          rx_cont, tx_cont, rx_en_o, rx_clr_o, tx_en_o, tx_clr_o;
  logic          rx_en_i, rx_pend_i, tx_en_i, tx_pend_i;
  logic          tx_req, tx_gnt, tx_valid, tx_ready;
  logic [31:0]   tx_data, rx_data;
  logic          rx_valid, rx_ready, uart_rx, uart_tx, ev_char, ev_err;

  always #5 clk = ~clk;

  udma_uart_core #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS)) dut (
    .sys_clk_i(clk), .rst_i(rst),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr), .cfg_valid_i(cfg_valid), .cfg_rwn_i(cfg_rwn),
    .cfg_ready_o(cfg_ready), .cfg_data_o(cfg_data_o),
    .cfg_rx_startaddr_o(rx_saddr), .cfg_rx_size_o(rx_size), .cfg_rx_datasize_o(rx_dsz),
    .cfg_rx_continuous_o(rx_cont), .cfg_rx_en_o(rx_en_o), .cfg_rx_clr_o(rx_clr_o),
    .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend_i), .cfg_rx_curr_addr_i(rx_curr),
    .cfg_rx_bytes_left_i(rx_left),
    .cfg_tx_startaddr_o(tx_saddr), .cfg_tx_size_o(tx_size), .cfg_tx_datasize_o(tx_dsz),
    .cfg_tx_continuous_o(tx_cont), .cfg_tx_en_o(tx_en_o), .cfg_tx_clr_o(tx_clr_o),
    .cfg_tx_en_i(tx_en_i), .cfg_tx_pending_i(tx_pend_i), .cfg_tx_curr_addr_i(tx_curr),
    .cfg_tx_bytes_left_i(tx_left),
    .data_tx_req_o(tx_req), .data_tx_gnt_i(tx_gnt), .data_tx_datasize_o(dtx_dsz),
    .data_tx_i(tx_data), .data_tx_valid_i(tx_valid), .data_tx_ready_o(tx_ready),
    .data_rx_o(rx_data), .data_rx_datasize_o(drx_dsz), .data_rx_valid_o(rx_valid),
    .data_rx_ready_i(rx_ready), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
    .rx_char_event_o(ev_char), .err_event_o(ev_err)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  exp_tx_q[$];
  int n_char = 0, n_err = 0, n_rxen = 0, n_rxclr = 0, n_txclr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Register read monitor: compares combinational read data while a read is presented.
  always @(negedge clk) begin
    if (!rst && cfg_valid && cfg_rwn) begin
      if (exp_rd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read addr=0x%0h actual=0x%0h required=none", cfg_addr, cfg_data_o);
      end else begin
        chk($sformatf("read_0x%0h", cfg_addr), cfg_data_o, exp_rd_q.pop_front());
      end
    end
  end

  // RX data monitor: compares on each accepted handshake.
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_rx_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rx actual=0x%0h required=none", rx_data);
      end else begin
        chk("rx_data", rx_data, {24'b0, exp_rx_q.pop_front()});
      end
    end
  end

  // Pulse counters (cycles high, so a stretched pulse shows as >1).
  always @(negedge clk) begin
    if (ev_char)  n_char++;
    if (ev_err)   n_err++;
    if (rx_en_o)  n_rxen++;
    if (rx_clr_o) n_rxclr++;
    if (tx_clr_o) n_txclr++;
  end

  // TX line monitor: 8N1, 4 cycles per bit; every cycle of every bit must match.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic [9:0] pat;
    logic       act;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && !uart_tx) begin
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_tx_frame actual=start required=idle");
        end else begin
          b   = exp_tx_q.pop_front();
          pat = {1'b1, b, 1'b0};
          for (int i = 0; i < 10; i++) begin
            act = pat[i];
            for (int c = 0; c < 4; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (uart_tx !== pat[i]) act = uart_tx;
            end
            chk($sformatf("tx_bit%0d", i), {31'b0, act}, {31'b0, pat[i]});
          end
        end
      end
      prev = uart_tx;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_rwn = 1'b0; cfg_addr = a; cfg_data_i = d;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, input logic [31:0] e);
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_rwn = 1'b1; cfg_addr = a;
    exp_rd_q.push_back(e);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // 8 data bits, parity bit, one stop bit at 4 cycles per bit.
  task automatic send_rx(input logic [7:0] d, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask

  task automatic wait_rx_valid();
    for (int i = 0; i < 20 && !rx_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("rx_valid_rise", {31'b0, rx_valid}, 32'd1);
  endtask

  task automatic accept_rx();
    @(posedge clk); #1; rx_ready = 1'b1;
    @(posedge clk); #1; rx_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] addrs[12];
    rst = 1'b1; cfg_data_i = '0; cfg_addr = '0; cfg_valid = 1'b0; cfg_rwn = 1'b0;
    rx_en_i = 1'b0; rx_pend_i = 1'b0; tx_en_i = 1'b0; tx_pend_i = 1'b0;
    rx_curr = '0; tx_curr = '0; rx_left = '0; tx_left = '0;
    tx_gnt = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; uart_rx = 1'b1;
    cycles(3);
    chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_tx_req", {31'b0, tx_req}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    rst = 1'b0;
    addrs = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B};
    foreach (addrs[i]) rd_reg(addrs[i], 32'h0);

    // SETUP readback; TX requests but the line stays idle without a grant.
    wr_reg(5'h09, 32'h01B10308);
    rd_reg(5'h09, 32'h01B10308);
    cycles(10);
    chk("tx_req_pending", {31'b0, tx_req}, 32'd1);
    chk("tx_idle_line", {31'b0, uart_tx}, 32'd1);
    rd_reg(5'h08, 32'h1);

    // TX frame 0xA5, 8N1, clkdiv 3.
    wr_reg(5'h09, 32'h00030106);
    exp_tx_q.push_back(8'hA5);
    @(posedge clk); #1; tx_gnt = 1'b1;
    @(posedge clk); #1; tx_gnt = 1'b0;
    for (int i = 0; i < 20 && !tx_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("tx_ready", {31'b0, tx_ready}, 32'd1);
    tx_data = 32'hFFFF_FFA5; tx_valid = 1'b1;
    @(posedge clk); #1; tx_valid = 1'b0;
    chk("tx_start_low", {31'b0, uart_tx}, 32'd0);
    cycles(50);

    // RX with even parity, IRQs enabled.
    wr_reg(5'h09, 32'h00030207);
    wr_reg(5'h0B, 32'h3);
    exp_rx_q.push_back(8'h55);
    send_rx(8'h55, 1'b0);
    wait_rx_valid();
    cycles(2);
    chk("char_events_1", n_char, 32'd1);
    chk("err_events_0", n_err, 32'd0);
    rd_reg(5'h0A, 32'h0);
    accept_rx();
    cycles(1);
    chk("rx_valid_clear", {31'b0, rx_valid}, 32'd0);

    // Parity error: character still delivered, ERROR bit1 read-clears.
    exp_rx_q.push_back(8'h55);
    send_rx(8'h55, 1'b1);
    wait_rx_valid();
    cycles(2);
    chk("char_events_2", n_char, 32'd2);
    chk("err_events_1", n_err, 32'd1);
    rd_reg(5'h0A, 32'h2);
    rd_reg(5'h0A, 32'h0);
    accept_rx();

    // Overflow: second character dropped, first retained.
    exp_rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b0);
    cycles(4);
    send_rx(8'hC3, 1'b0);
    cycles(4);
    chk("char_events_3", n_char, 32'd3);
    chk("err_events_2", n_err, 32'd2);
    chk("ovf_retained", rx_data, 32'h3C);
    rd_reg(5'h0A, 32'h1);
    accept_rx();
    cycles(1);
    chk("rx_valid_clear2", {31'b0, rx_valid}, 32'd0);

    // Channel configuration and command pulses.
    rx_en_i = 1'b1;
    wr_reg(5'h02, 32'h11);
    cycles(3);
    chk("rx_en_pulse_cycles", n_rxen, 32'd1);
    chk("rx_clr_pulse_cycles", n_rxclr, 32'd0);
    chk("rx_continuous", {31'b0, rx_cont}, 32'd1);
    rd_reg(5'h02, 32'h11);
    wr_reg(5'h06, 32'h21);
    cycles(3);
    chk("tx_clr_pulse_cycles", n_txclr, 32'd1);
    chk("tx_continuous", {31'b0, tx_cont}, 32'd1);
    wr_reg(5'h00, 32'h0001_2345);
    chk("rx_startaddr", 32'(rx_saddr), 32'h12345);
    wr_reg(5'h05, 32'h000A_BCDE);
    chk("tx_size", 32'(tx_size), 32'hABCDE);
    tx_curr = 19'h2A5A5;
    rd_reg(5'h04, 32'h2A5A5);

    // Reset returns outputs to their idle values.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_uart_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst2_tx_req", {31'b0, tx_req}, 32'd0);
    chk("rst2_rx_cont", {31'b0, rx_cont}, 32'd0);
    rst = 1'b0;
    cycles(5);
    chk("pending_reads", exp_rd_q.size(), 32'd0);
    chk("pending_rx", exp_rx_q.size(), 32'd0);
    chk("pending_tx", exp_tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
